// File: rtl/id_pipe.sv
// Registered RV32I (+M, +Zicsr) decode stage with a one-entry output register,
// valid/ready on both sides, a long-latency write scoreboard and flush.
module id_pipe #(
  parameter int  XLEN    = 32,
  parameter int  REG_NUM = 32,
  parameter int  M_EXT   = 1,
  parameter int  CSR_EN  = 1,
  localparam int RA_W    = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] inst_addr_i,
  input  logic            flush_i,
  output logic [RA_W-1:0] reg1_raddr_o,
  output logic [RA_W-1:0] reg2_raddr_o,
  input  logic [XLEN-1:0] reg1_rdata_i,
  input  logic [XLEN-1:0] reg2_rdata_i,
  output logic [XLEN-1:0] csr_raddr_o,
  input  logic [XLEN-1:0] csr_rdata_i,
  input  logic            wb_valid_i,
  input  logic [RA_W-1:0] wb_addr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_inst_o,
  output logic [XLEN-1:0] out_inst_addr_o,
  output logic [XLEN-1:0] out_reg1_rdata_o,
  output logic [XLEN-1:0] out_reg2_rdata_o,
  output logic            out_reg_we_o,
  output logic [RA_W-1:0] out_reg_waddr_o,
  output logic            out_csr_we_o,
  output logic [XLEN-1:0] out_csr_waddr_o,
  output logic [XLEN-1:0] out_csr_rdata_o,
  output logic            out_mem_req_o,
  output logic            out_illegal_o
);
  localparam logic [6:0] OP_IMM = 7'b0010011, OP     = 7'b0110011, LOAD  = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011, BRANCH = 7'b1100011, JAL   = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111, LUI    = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111, SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_Z   = 7'b0000000, F7_ALT = 7'b0100000, F7_M  = 7'b0000001;
  localparam logic [REG_NUM-1:0] SB_ONE = {{(REG_NUM-1){1'b0}}, 1'b1};

  logic [6:0]      w_op, w_f7;
  logic [2:0]      w_f3;
  logic            w_ok, w_rs1, w_rs2, w_we, w_ll, w_mem, w_csr;
  logic [RA_W-1:0] w_rs1_a, w_rs2_a, w_rd_a, w_waddr;
  logic            w_hazard, w_acc;
  logic [REG_NUM-1:0] w_sb_set, w_sb_clr;

  logic [REG_NUM-1:0] r_sb;
  logic            r_vld;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_addr, r_rd1, r_rd2, r_csr_wa, r_csr_rd;
  logic            r_we, r_csr_we, r_mem, r_ill;
  logic [RA_W-1:0] r_wa;

  assign w_op    = inst_i[6:0];
  assign w_f3    = inst_i[14:12];
  assign w_f7    = inst_i[31:25];
  assign w_rs1_a = RA_W'(inst_i[19:15]);
  assign w_rs2_a = RA_W'(inst_i[24:20]);
  assign w_rd_a  = RA_W'(inst_i[11:7]);

  always_comb begin
    w_ok  = 1'b0;
    w_rs1 = 1'b0;
    w_rs2 = 1'b0;
    w_we  = 1'b0;
    w_ll  = 1'b0;
    w_mem = 1'b0;
    w_csr = 1'b0;
    case (w_op)
      OP_IMM: begin
        w_ok  = (w_f3 == 3'b001) ? (w_f7 == F7_Z) :
                (w_f3 == 3'b101) ? (w_f7 == F7_Z || w_f7 == F7_ALT) : 1'b1;
        w_rs1 = 1'b1;
        w_we  = 1'b1;
      end
      OP: begin
        w_rs1 = 1'b1;
        w_rs2 = 1'b1;
        if (w_f7 == F7_Z) begin
          w_ok = 1'b1;
          w_we = 1'b1;
        end else if (w_f7 == F7_ALT) begin
          w_ok = (w_f3 == 3'b000 || w_f3 == 3'b101);
          w_we = 1'b1;
        end else if (w_f7 == F7_M && M_EXT != 0) begin
          // DIV/REM retire through the long-latency writeback, not ex
          w_ok = 1'b1;
          w_we = !w_f3[2];
          w_ll = w_f3[2];
        end
      end
      LOAD: begin
        w_ok  = (w_f3 != 3'b011 && w_f3[2:1] != 2'b11);
        w_rs1 = 1'b1;
        w_we  = 1'b1;
        w_ll  = 1'b1;
        w_mem = 1'b1;
      end
      STORE: begin
        w_ok  = (!w_f3[2] && w_f3 != 3'b011);
        w_rs1 = 1'b1;
        w_rs2 = 1'b1;
        w_mem = 1'b1;
      end
      BRANCH: begin
        w_ok  = (w_f3[2:1] != 2'b01);
        w_rs1 = 1'b1;
        w_rs2 = 1'b1;
      end
      JAL, LUI, AUIPC: begin
        w_ok = 1'b1;
        w_we = 1'b1;
      end
      JALR: begin
        w_ok  = (w_f3 == 3'b000);
        w_rs1 = 1'b1;
        w_we  = 1'b1;
      end
      FENCE: w_ok = (w_f3[2:1] == 2'b00);
      SYSTEM: begin
        w_ok  = (CSR_EN != 0) && (w_f3[1:0] != 2'b00);
        w_rs1 = !w_f3[2];
        w_we  = 1'b1;
        w_csr = 1'b1;
      end
      default: ;
    endcase
    if (!w_ok) begin
      w_rs1 = 1'b0;
      w_rs2 = 1'b0;
      w_we  = 1'b0;
      w_ll  = 1'b0;
      w_mem = 1'b0;
      w_csr = 1'b0;
    end
  end

  assign reg1_raddr_o = w_rs1 ? w_rs1_a : '0;
  assign reg2_raddr_o = w_rs2 ? w_rs2_a : '0;
  assign csr_raddr_o  = w_csr ? XLEN'(inst_i[31:20]) : '0;
  assign w_waddr      = (w_we || w_ll) ? w_rd_a : '0;

  // RAW on sources, WAW only against an outstanding long-latency writer
  assign w_hazard = (w_rs1 && r_sb[w_rs1_a]) || (w_rs2 && r_sb[w_rs2_a]) ||
                    (w_ll && r_sb[w_rd_a]);
  assign in_ready_o = !w_hazard && !flush_i && (!r_vld || out_ready_i);
  assign w_acc      = in_valid_i && in_ready_o;

  assign w_sb_set = (w_acc && w_ll) ? (SB_ONE << w_rd_a) : '0;
  assign w_sb_clr = wb_valid_i ? (SB_ONE << wb_addr_i) : '0;

  // set after clear so a same-edge set wins; bit 0 is forced idle
  always_ff @(posedge clk) begin
    if (rst) r_sb <= '0;
    else     r_sb <= ((r_sb & ~w_sb_clr) | w_sb_set) & ~SB_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_inst   <= 32'h0000_0013;
      r_addr   <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_we     <= 1'b0;
      r_wa     <= '0;
      r_csr_we <= 1'b0;
      r_csr_wa <= '0;
      r_csr_rd <= '0;
      r_mem    <= 1'b0;
      r_ill    <= 1'b0;
    end else if (flush_i) begin
      r_vld <= 1'b0;
    end else if (w_acc) begin
      r_vld    <= 1'b1;
      r_inst   <= inst_i;
      r_addr   <= inst_addr_i;
      r_rd1    <= reg1_rdata_i;
      r_rd2    <= reg2_rdata_i;
      r_we     <= w_we;
      r_wa     <= w_waddr;
      r_csr_we <= w_csr;
      r_csr_wa <= csr_raddr_o;
      r_csr_rd <= csr_rdata_i;
      r_mem    <= w_mem;
      r_ill    <= !w_ok;
    end else if (out_ready_i) begin
      r_vld <= 1'b0;
    end
  end

  assign out_valid_o      = r_vld;
  assign out_inst_o       = r_inst;
  assign out_inst_addr_o  = r_addr;
  assign out_reg1_rdata_o = r_rd1;
  assign out_reg2_rdata_o = r_rd2;
  assign out_reg_we_o     = r_we;
  assign out_reg_waddr_o  = r_wa;
  assign out_csr_we_o     = r_csr_we;
  assign out_csr_waddr_o  = r_csr_wa;
  assign out_csr_rdata_o  = r_csr_rd;
  assign out_mem_req_o    = r_mem;
  assign out_illegal_o    = r_ill;
endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: an opcode mask/match table drives a reference
// model of acceptance; a monitor checks every presented output.
module tb_id_pipe;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] REGHI = 32'h0198_0C00;

  logic        clk = 1'b0;
  logic        rst, in_valid_i, flush_i, out_ready_i, wb_valid_i;
  logic [31:0] inst_i, inst_addr_i;
  logic [4:0]  wb_addr_i;
  logic        in_ready_o, out_valid_o, out_reg_we_o, out_csr_we_o, out_mem_req_o, out_illegal_o;
  logic [4:0]  reg1_raddr_o, reg2_raddr_o, out_reg_waddr_o;
  logic [31:0] reg1_rdata_i, reg2_rdata_i, csr_raddr_o, csr_rdata_i;
  logic [31:0] out_inst_o, out_inst_addr_o, out_reg1_rdata_o, out_reg2_rdata_o;
  logic [31:0] out_csr_waddr_o, out_csr_rdata_o;

  logic        m0_in_ready, m0_valid, m0_we, m0_csr_we, m0_mem, m0_ill;
  logic [4:0]  m0_ra1, m0_ra2, m0_wa;
  logic [31:0] m0_csr_ra, m0_inst, m0_addr, m0_rd1, m0_rd2, m0_csr_wa, m0_csr_rd;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : {a, 3'b101, a, 3'b010, a, 3'b110, a, 3'b001};
  endfunction
  function automatic logic [31:0] cf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_55AA;
  endfunction

  assign reg1_rdata_i = rf(reg1_raddr_o);
  assign reg2_rdata_i = rf(reg2_raddr_o);
  assign csr_rdata_i  = cf(csr_raddr_o);

  id_pipe dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .flush_i(flush_i),
    .reg1_raddr_o(reg1_raddr_o), .reg2_raddr_o(reg2_raddr_o),
    .reg1_rdata_i(reg1_rdata_i), .reg2_rdata_i(reg2_rdata_i),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
    .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_inst_o(out_inst_o),
    .out_inst_addr_o(out_inst_addr_o), .out_reg1_rdata_o(out_reg1_rdata_o),
    .out_reg2_rdata_o(out_reg2_rdata_o), .out_reg_we_o(out_reg_we_o),
    .out_reg_waddr_o(out_reg_waddr_o), .out_csr_we_o(out_csr_we_o),
    .out_csr_waddr_o(out_csr_waddr_o), .out_csr_rdata_o(out_csr_rdata_o),
    .out_mem_req_o(out_mem_req_o), .out_illegal_o(out_illegal_o)
  );

  id_pipe #(.M_EXT(0)) dut_m0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(m0_in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .flush_i(1'b0),
    .reg1_raddr_o(m0_ra1), .reg2_raddr_o(m0_ra2),
    .reg1_rdata_i(32'd0), .reg2_rdata_i(32'd0),
    .csr_raddr_o(m0_csr_ra), .csr_rdata_i(32'd0),
    .wb_valid_i(1'b0), .wb_addr_i(5'd0),
    .out_valid_o(m0_valid), .out_ready_i(1'b1), .out_inst_o(m0_inst),
    .out_inst_addr_o(m0_addr), .out_reg1_rdata_o(m0_rd1), .out_reg2_rdata_o(m0_rd2),
    .out_reg_we_o(m0_we), .out_reg_waddr_o(m0_wa), .out_csr_we_o(m0_csr_we),
    .out_csr_waddr_o(m0_csr_wa), .out_csr_rdata_o(m0_csr_rd),
    .out_mem_req_o(m0_mem), .out_illegal_o(m0_ill)
  );

  // attribute bits: 0 rs1, 1 rs2, 2 we, 3 long-latency, 4 mem, 5 csr
  typedef struct packed { logic [31:0] mask, match; logic [5:0] at; } ent_t;
  typedef struct {
    logic [31:0] inst, addr, r1, r2, csr_wa, csr_rd;
    logic        we, csr_we, mem, ill;
    logic [4:0]  wa;
  } exp_t;

  ent_t        tbl[$];
  exp_t        q[$];
  int          n_chk = 0, n_fail = 0;
  bit   [31:0] busy;
  bit          m_ov;
  logic [31:0] pc;

  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  function automatic void add(input logic [31:0] mk, input logic [31:0] mt, input logic [5:0] at);
    tbl.push_back('{mk, mt, at});
  endfunction

  function automatic logic [6:0] lookup(input logic [31:0] w);
    foreach (tbl[i]) if ((w & tbl[i].mask) == tbl[i].match) return {1'b1, tbl[i].at};
    return 7'd0;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] w, input logic [31:0] a);
    exp_t        e;
    logic [6:0]  l;
    logic [31:0] ca;
    l  = lookup(w);
    ca = l[5] ? {20'd0, w[31:20]} : 32'd0;
    e.inst   = w;
    e.addr   = a;
    e.r1     = rf(l[0] ? w[19:15] : 5'd0);
    e.r2     = rf(l[1] ? w[24:20] : 5'd0);
    e.we     = l[2];
    e.wa     = (l[2] || l[3]) ? w[11:7] : 5'd0;
    e.csr_we = l[5];
    e.csr_wa = ca;
    e.csr_rd = cf(ca);
    e.mem    = l[4];
    e.ill    = !l[6];
    return e;
  endfunction

  task automatic cyc(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                     input bit wv, input logic [4:0] wa, input bit rs);
    logic [6:0] l;
    bit hz, rdy, acc;
    in_valid_i = v; inst_i = w; out_ready_i = ordy; flush_i = fl;
    wb_valid_i = wv; wb_addr_i = wa; rst = rs; inst_addr_i = pc;
    l   = lookup(w);
    hz  = (l[0] && busy[w[19:15]]) || (l[1] && busy[w[24:20]]) || (l[3] && busy[w[11:7]]);
    rdy = !hz && !fl && (!m_ov || ordy);
    acc = v && rdy;
    @(negedge clk);
    if (!rs) begin
      chk("in_ready", 32'(in_ready_o), 32'(rdy));
      chk("out_valid", 32'(out_valid_o), 32'(m_ov));
      chk("reg1_raddr", 32'(reg1_raddr_o), 32'(l[0] ? w[19:15] : 5'd0));
      chk("reg2_raddr", 32'(reg2_raddr_o), 32'(l[1] ? w[24:20] : 5'd0));
      chk("csr_raddr", csr_raddr_o, l[5] ? {20'd0, w[31:20]} : 32'd0);
      if (acc) q.push_back(mk_exp(w, pc));
    end
    @(posedge clk);
    if (rs) begin
      m_ov = 1'b0;
      busy = '0;
      q.delete();
    end else begin
      if (fl)        m_ov = 1'b0;
      else if (acc)  m_ov = 1'b1;
      else if (ordy) m_ov = 1'b0;
      if (wv) busy[wa] = 1'b0;
      if (acc && l[3] && w[11:7] != 5'd0) busy[w[11:7]] = 1'b1;
    end
    pc = pc + 32'd4;
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid_o) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid_o=1 inst %h with no expected entry", out_inst_o);
      end else begin
        e = q[0];
        chk("out_inst", out_inst_o, e.inst);
        chk("out_inst_addr", out_inst_addr_o, e.addr);
        chk("out_reg1_rdata", out_reg1_rdata_o, e.r1);
        chk("out_reg2_rdata", out_reg2_rdata_o, e.r2);
        chk("out_reg_we", 32'(out_reg_we_o), 32'(e.we));
        chk("out_reg_waddr", 32'(out_reg_waddr_o), 32'(e.wa));
        chk("out_csr_we", 32'(out_csr_we_o), 32'(e.csr_we));
        chk("out_csr_waddr", out_csr_waddr_o, e.csr_wa);
        chk("out_csr_rdata", out_csr_rdata_o, e.csr_rd);
        chk("out_mem_req", 32'(out_mem_req_o), 32'(e.mem));
        chk("out_illegal", 32'(out_illegal_o), 32'(e.ill));
        if (out_ready_i || flush_i) void'(q.pop_front());
      end
    end
  end

  initial begin
    int lf[$], sf[$], bf[$];
    logic [31:0] w;
    ent_t        te;
    bit          wv;
    logic [4:0]  wa;
    int          bl[$];
    lf = '{0, 1, 2, 4, 5};
    sf = '{0, 1, 2};
    bf = '{0, 1, 4, 5, 6, 7};
    foreach (bf[i]) if (bf[i] != 1 && bf[i] != 5) add(32'h707F, 32'h13 | (bf[i] << 12), 6'h05);
    add(32'h707F, 32'h2013, 6'h05);
    add(32'h707F, 32'h3013, 6'h05);
    add(32'hFE00707F, 32'h0000_1013, 6'h05);
    add(32'hFE00707F, 32'h0000_5013, 6'h05);
    add(32'hFE00707F, 32'h4000_5013, 6'h05);
    for (int f = 0; f < 8; f++) add(32'hFE00707F, 32'h33 | (f << 12), 6'h07);
    add(32'hFE00707F, 32'h4000_0033, 6'h07);
    add(32'hFE00707F, 32'h4000_5033, 6'h07);
    for (int f = 0; f < 4; f++) add(32'hFE00707F, 32'h0200_0033 | (f << 12), 6'h07);
    for (int f = 4; f < 8; f++) add(32'hFE00707F, 32'h0200_0033 | (f << 12), 6'h0B);
    foreach (lf[i]) add(32'h707F, 32'h03 | (lf[i] << 12), 6'h1D);
    foreach (sf[i]) add(32'h707F, 32'h23 | (sf[i] << 12), 6'h13);
    foreach (bf[i]) add(32'h707F, 32'h63 | (bf[i] << 12), 6'h03);
    add(32'h7F, 32'h6F, 6'h04);
    add(32'h7F, 32'h37, 6'h04);
    add(32'h7F, 32'h17, 6'h04);
    add(32'h707F, 32'h67, 6'h05);
    add(32'h707F, 32'h0F, 6'h00);
    add(32'h707F, 32'h100F, 6'h00);
    for (int f = 1; f < 4; f++) add(32'h707F, 32'h73 | (f << 12), 6'h25);
    for (int f = 5; f < 8; f++) add(32'h707F, 32'h73 | (f << 12), 6'h24);

    pc = 32'h8000_0000; busy = '0; m_ov = 1'b0;
    rst = 1'b1; in_valid_i = 0; inst_i = NOP; out_ready_i = 0; flush_i = 0;
    wb_valid_i = 0; wb_addr_i = 0; inst_addr_i = 0;
    cyc(0, NOP, 1, 0, 0, 0, 1);
    cyc(0, NOP, 1, 0, 0, 0, 1);
    chk("rst out_valid", 32'(out_valid_o), 32'd0);
    chk("rst out_inst", out_inst_o, NOP);
    chk("rst out_inst_addr", out_inst_addr_o, 32'd0);
    chk("rst out_reg_we", 32'(out_reg_we_o), 32'd0);
    chk("rst out_reg1_rdata", out_reg1_rdata_o, 32'd0);
    chk("rst out_mem_req", 32'(out_mem_req_o), 32'd0);
    chk("rst out_illegal", 32'(out_illegal_o), 32'd0);

    // ADDI x5,x1,7
    cyc(1, 32'h0070_8293, 1, 0, 0, 0, 0);
    cyc(0, NOP, 1, 0, 0, 0, 0);
    // LW x3,0(x2) then ADD x4,x3,x1 stalls until writeback of x3
    cyc(1, 32'h0001_2183, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 32'h0011_8233, 1, 0, 0, 0, 0);
    cyc(1, 32'h0011_8233, 1, 0, 1, 5'd3, 0);
    cyc(1, 32'h0011_8233, 1, 0, 0, 0, 0);
    // DIV x6, then LW x6 accepted on the same edge as a writeback of x6
    cyc(1, 32'h0220_C333, 1, 0, 0, 0, 0);
    cyc(0, NOP, 1, 0, 1, 5'd6, 0);
    cyc(1, 32'h0001_2303, 1, 0, 1, 5'd6, 0);
    repeat (2) cyc(1, 32'h0013_04B3, 1, 0, 0, 0, 0);
    cyc(1, 32'h0013_04B3, 1, 0, 1, 5'd6, 0);
    cyc(1, 32'h0013_04B3, 1, 0, 0, 0, 0);
    // output back-pressure for 3 cycles, then back-to-back
    cyc(1, 32'h0070_8293, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, 32'h0051_0513, 0, 0, 0, 0, 0);
    cyc(1, 32'h0051_0513, 1, 0, 0, 0, 0);
    cyc(1, 32'h0070_8293, 1, 0, 0, 0, 0);
    // flush with valid output and valid input; scoreboard keeps x3 busy
    cyc(1, 32'h0001_2183, 1, 0, 0, 0, 0);
    cyc(1, 32'h0051_0513, 1, 1, 0, 0, 0);
    cyc(1, 32'h0011_8233, 1, 0, 0, 0, 0);
    cyc(0, NOP, 1, 0, 1, 5'd3, 0);
    // illegal word
    cyc(1, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    cyc(0, NOP, 1, 0, 0, 0, 0);
    // reset during a stall, then MUL (illegal on the M_EXT=0 instance)
    cyc(1, 32'h0001_2383, 1, 0, 0, 0, 0);
    cyc(1, 32'h0013_8433, 0, 0, 0, 0, 0);
    cyc(1, 32'h0013_8433, 0, 0, 0, 0, 1);
    cyc(1, 32'h0231_00B3, 1, 0, 0, 0, 0);
    chk("m0 out_valid", 32'(m0_valid), 32'd1);
    chk("m0 out_inst", m0_inst, 32'h0231_00B3);
    chk("m0 out_illegal", 32'(m0_ill), 32'd1);
    chk("m0 out_reg_we", 32'(m0_we), 32'd0);
    chk("m0 enables", {29'd0, m0_csr_we, m0_mem, 1'b0} | 32'(m0_wa), 32'd0);
    cyc(1, 32'h0013_8433, 1, 0, 0, 0, 0);
    cyc(0, NOP, 1, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) < 8) w = $urandom;
      else begin
        te = tbl[$urandom_range(0, tbl.size() - 1)];
        w  = (te.match | ($urandom & ~te.mask)) & ~(REGHI & ~te.mask);
      end
      bl.delete();
      for (int r = 1; r < 32; r++) if (busy[r]) bl.push_back(r);
      wv = 0; wa = 0;
      if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
        wv = 1;
        wa = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        wv = 1;
        wa = 5'($urandom_range(0, 31));
      end
      cyc($urandom_range(0, 9) < 8, w, $urandom_range(0, 3) != 0,
          $urandom_range(0, 19) == 0, wv, wa, 0);
    end
    repeat (3) cyc(0, NOP, 1, 0, 0, 0, 0);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
